// File: rtl/rgmii_tx_encoder_if.sv
// rgmii_tx_encoder_if
// Byte-stream handshake between a frame source and the RGMII TX encoder.
//   tdata  : frame byte
//   tvalid : byte valid
//   tlast  : last byte of frame
//   tuser  : byte carries a tx error
//   tready : byte accepted when tvalid & tready
// Modports: master (source side), slave (encoder side).
interface rgmii_tx_encoder_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rgmii_tx_encoder.sv
// rgmii_tx_encoder
// Turns a byte stream into RGMII rise/fall nibble pairs for an external ODDR stage.
// All RGMII outputs are registered: a byte's nibbles appear the cycle after its slot begins.
// Ports:
//   clk              : single clock (125/25/2.5 MHz by link speed)
//   reset_n          : synchronous, active-low reset
//   link_speed       : 00 = 1G, 01 = 100M, 10 = 10M, 11 = 1G; sampled on a frame's first byte
//   s_tx             : byte stream (slave modport of rgmii_tx_encoder_if)
//   rgmii_txd_rise   : nibble for the rising edge
//   rgmii_txd_fall   : nibble for the falling edge
//   rgmii_txctl_rise : TX_EN
//   rgmii_txctl_fall : TX_EN xor TX_ER
// Build option:
//   RGMII_TX_IFG_EN  : when defined, a 12 byte-time inter-frame gap is enforced after tlast;
//                      when undefined, the encoder returns straight to idle and upstream
//                      owns gap insertion.
module rgmii_tx_encoder (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        link_speed,
    rgmii_tx_encoder_if.slave s_tx,
    output logic [3:0]        rgmii_txd_rise,
    output logic [3:0]        rgmii_txd_fall,
    output logic              rgmii_txctl_rise,
    output logic              rgmii_txctl_fall
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StTxLo = 2'd1,
`ifdef RGMII_TX_IFG_EN
        StTxHi = 2'd2,
        StIfg  = 2'd3
`else
        StTxHi = 2'd2
`endif
    } state_e;

    state_e     r_state;
    logic       r_tready;
    logic       r_slow;      // frame runs at 10/100 (two cycles per byte)
    logic [3:0] r_hi_nib;    // upper nibble still owed at 10/100
    logic       r_user;
    logic       r_last;
    logic [3:0] r_txd_rise;
    logic [3:0] r_txd_fall;
    logic       r_txctl_rise;
    logic       r_txctl_fall;
`ifdef RGMII_TX_IFG_EN
    logic [4:0] r_ifg_cnt;
`endif

    logic w_accept;
    logic w_slow;

    assign w_accept = s_tx.tvalid & r_tready;
    // Speed comes from the pin only when a frame starts; afterwards the latched value rules.
    assign w_slow   = (r_state == StIdle) ? (link_speed == 2'b01 || link_speed == 2'b10)
                                          : r_slow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_tready     <= 1'b0;
            r_slow       <= 1'b0;
            r_hi_nib     <= 4'd0;
            r_user       <= 1'b0;
            r_last       <= 1'b0;
            r_txd_rise   <= 4'd0;
            r_txd_fall   <= 4'd0;
            r_txctl_rise <= 1'b0;
            r_txctl_fall <= 1'b0;
`ifdef RGMII_TX_IFG_EN
            r_ifg_cnt    <= 5'd0;
`endif
        end else begin
            // Wire idles unless a branch below drives a slot.
            r_txd_rise   <= 4'd0;
            r_txd_fall   <= 4'd0;
            r_txctl_rise <= 1'b0;
            r_txctl_fall <= 1'b0;
            unique case (r_state)
                StIdle, StTxHi: begin
                    if (w_accept) begin
                        r_slow       <= w_slow;
                        r_hi_nib     <= s_tx.tdata[7:4];
                        r_user       <= s_tx.tuser;
                        r_last       <= s_tx.tlast;
                        r_txd_rise   <= s_tx.tdata[3:0];
                        r_txctl_rise <= 1'b1;
                        r_txctl_fall <= ~s_tx.tuser;
                        if (w_slow) begin
                            r_txd_fall <= s_tx.tdata[3:0];
                            r_state    <= StTxLo;
                            r_tready   <= 1'b0;
                        end else begin
                            r_txd_fall <= s_tx.tdata[7:4];
                            if (s_tx.tlast) begin
`ifdef RGMII_TX_IFG_EN
                                r_state   <= StIfg;
                                r_tready  <= 1'b0;
                                r_ifg_cnt <= 5'd11;
`else
                                r_state   <= StIdle;
                                r_tready  <= 1'b1;
`endif
                            end else begin
                                r_state  <= StTxHi;
                                r_tready <= 1'b1;
                            end
                        end
                    end else if (r_state == StTxHi) begin
                        // Underrun: error slot (TX_EN=1, TX_ER=1, data 0), frame stays open.
                        r_txctl_rise <= 1'b1;
                        r_txctl_fall <= 1'b0;
                        if (r_slow) begin
                            // Second nibble of the error slot is emitted from StTxLo.
                            r_hi_nib <= 4'd0;
                            r_user   <= 1'b1;
                            r_last   <= 1'b0;
                            r_state  <= StTxLo;
                            r_tready <= 1'b0;
                        end
                    end else begin
                        r_tready <= 1'b1;
                    end
                end
                StTxLo: begin
                    r_txd_rise   <= r_hi_nib;
                    r_txd_fall   <= r_hi_nib;
                    r_txctl_rise <= 1'b1;
                    r_txctl_fall <= ~r_user;
                    if (r_last) begin
`ifdef RGMII_TX_IFG_EN
                        r_state   <= StIfg;
                        r_tready  <= 1'b0;
                        r_ifg_cnt <= 5'd23;
`else
                        r_state   <= StIdle;
                        r_tready  <= 1'b1;
`endif
                    end else begin
                        r_state  <= StTxHi;
                        r_tready <= 1'b1;
                    end
                end
`ifdef RGMII_TX_IFG_EN
                StIfg: begin
                    if (r_ifg_cnt == 5'd0) begin
                        r_state  <= StIdle;
                        r_tready <= 1'b1;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt - 5'd1;
                    end
                end
`endif
                default: begin
                    r_state  <= StIdle;
                    r_tready <= 1'b1;
                end
            endcase
        end
    end

    assign s_tx.tready      = r_tready;
    assign rgmii_txd_rise   = r_txd_rise;
    assign rgmii_txd_fall   = r_txd_fall;
    assign rgmii_txctl_rise = r_txctl_rise;
    assign rgmii_txctl_fall = r_txctl_fall;

endmodule
